// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: FSM encoding, field widths and
// the data word returned when a bus access is aborted.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StDone = 2'd2
    } state_t;

    localparam int unsigned REG_FILE_ADDR_LEN = 5;
    localparam int unsigned BASE_ADDR_DEF     = 1024;
    localparam logic [31:0] ABORT_DATA        = 32'hDEADBEEF;

endpackage

// File: rtl/mem_stage.sv
// MEM stage: runs loads/stores over a req/ack bus and freezes upstream until done.
// Optional bus timeout/abort is enabled with `define MEM_TIMEOUT_EN.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned BASE_ADDR = BASE_ADDR_DEF,
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         WB_EN_IN,
    input  logic                         MEM_R_EN_IN,
    input  logic                         MEM_W_EN_IN,
    input  logic [31:0]                  ALUResIn,
    input  logic [31:0]                  STValIn,
    input  logic [REG_FILE_ADDR_LEN-1:0] destIn,
    output logic                         WB_EN,
    output logic                         MEM_R_EN,
    output logic [31:0]                  ALURes,
    output logic [31:0]                  memReadVal,
    output logic [REG_FILE_ADDR_LEN-1:0] dest,
    output logic                         freeze,
    output logic                         mem_req,
    output logic                         mem_we,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [31:0]                  mem_wdata,
    input  logic                         mem_ack,
    input  logic [31:0]                  mem_rdata,
    output logic                         mem_err
);

    state_t      state_q;
    logic [31:0] rdata_q;
    logic        access;
    logic        busy;

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);
    logic [7:0] tmo_cnt_q;
    logic       mem_err_q;
`else
    localparam int unsigned unused_timeout = TIMEOUT;
`endif

    // A simultaneous load+store is treated as a load.
    assign access = MEM_R_EN_IN | MEM_W_EN_IN;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            rdata_q   <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            tmo_cnt_q <= '0;
            mem_err_q <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (access) begin
                        state_q   <= StWait;
                        mem_addr  <= ADDR_W'((ALUResIn - 32'(BASE_ADDR)) >> 2);
                        mem_wdata <= STValIn;
                        mem_we    <= MEM_W_EN_IN & ~MEM_R_EN_IN;
`ifdef MEM_TIMEOUT_EN
                        tmo_cnt_q <= '0;
`endif
                    end
                end
                StWait: begin
                    if (mem_ack) begin
                        state_q <= StDone;
                        rdata_q <= mem_we ? 32'd0 : mem_rdata;
                    end
`ifdef MEM_TIMEOUT_EN
                    else begin
                        tmo_cnt_q <= tmo_cnt_q + 8'd1;
                        if (tmo_cnt_q + 8'd1 == TimeoutCnt) begin
                            state_q   <= StDone;
                            rdata_q   <= ABORT_DATA;
                            mem_err_q <= 1'b1;
                        end
                    end
`endif
                end
                StDone: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    // Stall from the cycle an access is seen until the bus completes; DONE releases.
    assign busy       = (state_q == StWait) || ((state_q == StIdle) && access);
    assign freeze     = busy;
    assign mem_req    = (state_q == StWait);
    assign WB_EN      = WB_EN_IN & ~busy;
    assign MEM_R_EN   = MEM_R_EN_IN & ~busy;
    assign ALURes     = ALUResIn;
    assign dest       = destIn;
    assign memReadVal = rdata_q;

`ifdef MEM_TIMEOUT_EN
    assign mem_err = mem_err_q;
`else
    assign mem_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected bus/result values queued at issue,
// popped and compared when the stage reaches its result cycle.
module tb_mem_stage;

    localparam int unsigned TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN;
    logic [31:0] ALUResIn, STValIn;
    logic [4:0]  destIn;
    logic        WB_EN, MEM_R_EN;
    logic [31:0] ALURes, memReadVal;
    logic [4:0]  dest;
    logic        freeze, mem_req, mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        mem_err;

    typedef struct {
        logic [31:0] rd;
        logic [9:0]  addr;
        logic        we;
        logic [31:0] wdata;
        int          frz;
        logic        wb;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   wb_pulses = 0;
    logic err_exp  = 1'b0;

    mem_stage #(
        .BASE_ADDR (1024),
        .ADDR_W    (10),
        .TIMEOUT   (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .WB_EN_IN    (WB_EN_IN),
        .MEM_R_EN_IN (MEM_R_EN_IN),
        .MEM_W_EN_IN (MEM_W_EN_IN),
        .ALUResIn    (ALUResIn),
        .STValIn     (STValIn),
        .destIn      (destIn),
        .WB_EN       (WB_EN),
        .MEM_R_EN    (MEM_R_EN),
        .ALURes      (ALURes),
        .memReadVal  (memReadVal),
        .dest        (dest),
        .freeze      (freeze),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .mem_err     (mem_err)
    );

    always #5 clk = ~clk;

    // MEM2WB sees a writeback on every edge where WB_EN is high.
    always @(posedge clk) if (rst && WB_EN) wb_pulses <= wb_pulses + 1;

    task automatic set_idle(input logic wb, input logic [31:0] res);
        WB_EN_IN    = wb;
        MEM_R_EN_IN = 1'b0;
        MEM_W_EN_IN = 1'b0;
        ALUResIn    = res;
        STValIn     = 32'd0;
        destIn      = 5'd0;
    endtask

    // ack_at = WAIT cycle carrying mem_ack (1 = first); 0 = never ack (timeout).
    task automatic do_access(input logic ld, input logic st, input logic [31:0] addr,
                             input logic [31:0] stval, input int ack_at,
                             input logic [31:0] rdata);
        exp_t e;
        int   frz = 0;
        int   wcyc = 0;
        int   bubble_bad = 0;
        bit   done = 0;
        @(negedge clk);
        WB_EN_IN    = ld;
        MEM_R_EN_IN = ld;
        MEM_W_EN_IN = st;
        ALUResIn    = addr;
        STValIn     = stval;
        destIn      = 5'd9;
        e.addr  = 10'((addr - 32'd1024) >> 2);
        e.we    = st & ~ld;
        e.wdata = stval;
        e.rd    = (ack_at == 0) ? 32'hDEADBEEF : (e.we ? 32'd0 : rdata);
        e.frz   = 1 + ((ack_at == 0) ? int'(TMO) : ack_at);
        e.wb    = ld;
        sb_q.push_back(e);
        if (ack_at == 0) err_exp = 1'b1;
        for (int cyc = 0; cyc < 300 && !done; cyc++) begin
            #1;
            if (freeze) begin
                frz++;
                if (WB_EN !== 1'b0 || MEM_R_EN !== 1'b0) bubble_bad++;
                if (mem_req) begin
                    wcyc++;
                    if (wcyc == 1) begin
                        n_checks++;
                        if (mem_addr !== e.addr || mem_we !== e.we || mem_wdata !== e.wdata) begin
                            n_fail++;
                            $display("FAIL bus_issue: addr=%h we=%b wdata=%h, want addr=%h we=%b wdata=%h",
                                     mem_addr, mem_we, mem_wdata, e.addr, e.we, e.wdata);
                        end
                    end
                    mem_ack   = (wcyc == ack_at);
                    mem_rdata = mem_ack ? rdata : $urandom;
                end
                @(negedge clk);
            end else begin
                done = 1;
            end
        end
        mem_ack = 1'b0;
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL access_done: freeze still high after %0d cycles, want release", frz);
        end
        e = sb_q.pop_front();
        n_checks++;
        if (frz !== e.frz || bubble_bad !== 0) begin
            n_fail++;
            $display("FAIL freeze_len: got %0d cycles (%0d non-bubble), want %0d cycles, 0",
                     frz, bubble_bad, e.frz);
        end
        n_checks++;
        if (memReadVal !== e.rd || WB_EN !== e.wb || MEM_R_EN !== e.wb) begin
            n_fail++;
            $display("FAIL result: rd=%h wb=%b mr=%b, want rd=%h wb=%b mr=%b",
                     memReadVal, WB_EN, MEM_R_EN, e.rd, e.wb, e.wb);
        end
        n_checks++;
        if (mem_req !== 1'b0 || mem_err !== err_exp) begin
            n_fail++;
            $display("FAIL done_bus: req=%b err=%b, want req=0 err=%b", mem_req, mem_err, err_exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        set_idle(1'b0, 32'd0);
        mem_ack = 1'b0;
        mem_rdata = 32'd0;
        #3;
        n_checks++;
        if (freeze !== 1'b0 || mem_req !== 1'b0 || mem_err !== 1'b0 || memReadVal !== 32'd0 ||
            mem_addr !== 10'd0 || mem_we !== 1'b0 || mem_wdata !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_state: frz=%b req=%b err=%b rd=%h addr=%h we=%b wd=%h, want all 0",
                     freeze, mem_req, mem_err, memReadVal, mem_addr, mem_we, mem_wdata);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_alu_op();
        @(negedge clk);
        set_idle(1'b1, 32'd5);
        destIn  = 5'd17;
        mem_ack = 1'b1;
        #1;
        n_checks++;
        if (freeze !== 1'b0 || ALURes !== 32'd5 || WB_EN !== 1'b1 || MEM_R_EN !== 1'b0 ||
            dest !== 5'd17) begin
            n_fail++;
            $display("FAIL alu_pass: frz=%b res=%h wb=%b mr=%b dest=%0d, want 0 5 1 0 17",
                     freeze, ALURes, WB_EN, MEM_R_EN, dest);
        end
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        n_checks++;
        if (mem_req !== 1'b0 || freeze !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_ack_ignored: req=%b frz=%b, want 0 0", mem_req, freeze);
        end
    endtask

    task automatic test_load();
        do_access(1'b1, 1'b0, 32'd1028, 32'd0, 3, 32'h0000_1234);
    endtask

    task automatic test_store();
        do_access(1'b0, 1'b1, 32'd1032, 32'h0000_00AA, 1, 32'hFFFF_FFFF);
    endtask

    task automatic test_corner_addr();
        // Below BASE_ADDR wraps; read wins over a simultaneous write.
        do_access(1'b1, 1'b0, 32'd0, 32'd0, 2, $urandom);
        do_access(1'b1, 1'b1, 32'd5116, 32'h5555_AAAA, 1, 32'hCAFE_F00D);
    endtask

    task automatic test_reset_mid_wait();
        @(negedge clk);
        WB_EN_IN = 1'b1; MEM_R_EN_IN = 1'b1; MEM_W_EN_IN = 1'b0;
        ALUResIn = 32'd2000;
        @(negedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        n_checks++;
        if (mem_req !== 1'b0 || mem_addr !== 10'd0 || memReadVal !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid_wait: req=%b addr=%h rd=%h, want 0 0 0",
                     mem_req, mem_addr, memReadVal);
        end
        set_idle(1'b0, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        n_checks++;
        if (freeze !== 1'b0 || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: frz=%b req=%b, want 0 0", freeze, mem_req);
        end
    endtask

    task automatic test_back_to_back();
        int start;
        @(negedge clk);
        set_idle(1'b0, 32'd0);
        #1;
        start = wb_pulses;
        do_access(1'b1, 1'b0, 32'd1100, 32'd0, 1, 32'h1111_0001);
        do_access(1'b1, 1'b0, 32'd1104, 32'd0, 2, 32'h2222_0002);
        @(negedge clk);
        set_idle(1'b0, 32'd0);
        @(negedge clk);
        #1;
        n_checks++;
        if (wb_pulses - start !== 2) begin
            n_fail++;
            $display("FAIL b2b_wb_pulses: got %0d, want 2", wb_pulses - start);
        end
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        do_access(1'b1, 1'b0, 32'd1200, 32'd0, 0, 32'd0);
        do_access(1'b0, 1'b1, 32'd1204, 32'h77, 1, 32'd0);
    endtask
`endif

    initial begin
        test_reset();
        test_alu_op();
        test_load();
        test_store();
        test_corner_addr();
        test_reset_mid_wait();
        test_back_to_back();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
